// File: rtl/time_of_day_counter_pkg.sv
// tod_pkg: time-of-day field limits, widths, packed time type and range check
package tod_pkg;
   localparam int HOURS_MAX = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;
   localparam int HOURS_W = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam int TIME_W = 17;
   typedef struct packed {
      logic [HOURS_W-1:0] hours;
      logic [MIN_W-1:0] minutes;
      logic [SEC_W-1:0] seconds;
   } tod_time_t;
   function automatic logic tod_valid(input tod_time_t t);
      return t.hours <= HOURS_W'(HOURS_MAX) && t.minutes <= MIN_W'(MIN_MAX) && t.seconds <= SEC_W'(SEC_MAX);
   endfunction
endpackage

// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if: control, load and time/pulse bundle; TOD_ALARM_EN adds alarm signals
interface time_of_day_counter_if #(
   parameter int NUM_LOAD = 2
);
   import tod_pkg::*;
   logic run;
   logic [NUM_LOAD-1:0] load;
   logic [NUM_LOAD*TIME_W-1:0] load_time;
   logic [HOURS_W-1:0] hours;
   logic [MIN_W-1:0] minutes;
   logic [SEC_W-1:0] seconds;
   logic sec_pulse, min_pulse, day_wrap, load_ack, load_err;
`ifdef TOD_ALARM_EN
   logic alarm_set;
   logic [TIME_W-1:0] alarm_time;
   logic alarm_ack;
   logic alarm;
`endif
   modport master (
`ifdef TOD_ALARM_EN
      output alarm_set, alarm_time, alarm_ack,
      input alarm,
`endif
      output run, load, load_time,
      input hours, minutes, seconds, sec_pulse, min_pulse, day_wrap, load_ack, load_err
   );
   modport slave (
`ifdef TOD_ALARM_EN
      input alarm_set, alarm_time, alarm_ack,
      output alarm,
`endif
      input run, load, load_time,
      output hours, minutes, seconds, sec_pulse, min_pulse, day_wrap, load_ack, load_err
   );
endinterface

// File: rtl/time_of_day_counter_prescaler.sv
// tod_prescaler: divides the system clock down to a one-cycle second tick
module tod_prescaler #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input logic clock,
   input logic reset,
   input logic run,
   input logic clear,
   output logic tick
);
   localparam int W = $clog2(TICKS_PER_SEC);
   localparam logic [W-1:0] TERM = W'(TICKS_PER_SEC - 1);
   logic [W-1:0] pre_q, pre_d;
   assign tick = run && pre_q == TERM;
   // restart on clear or terminal count, otherwise advance only while running
   always_comb pre_d = (clear || tick) ? '0 : run ? pre_q + 1'b1 : pre_q;
   // prescale counter register
   always_ff @(posedge clock or negedge reset)
      if (!reset) pre_q <= '0;
      else pre_q <= pre_d;
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: hh:mm:ss counter with prescaler and prioritised loads; TOD_ALARM_EN adds an alarm
module time_of_day_counter
   import tod_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int NUM_LOAD = 2
) (
   input logic clock,
   input logic reset,
   time_of_day_counter_if.slave bus
);
   tod_time_t time_q, time_d, sel, inc;
   logic hit, ok, tick, count, sec_end, min_end, hour_end;
   logic sec_pulse_q, min_pulse_q, day_wrap_q, load_ack_q, load_err_q;
   tod_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_pre (
      .clock(clock),
      .reset(reset),
      .run(bus.run),
      .clear(ok),
      .tick(tick)
   );
   // pick the lowest-index strobe; scanning high to low lets channel 0 overwrite the rest
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_LOAD - 1; i >= 0; i--)
         if (bus.load[i]) begin
            hit = 1'b1;
            sel = bus.load_time[TIME_W*i +: TIME_W];
         end
   end
   assign ok = hit && tod_valid(sel);
   assign count = tick && !ok;
   assign sec_end = time_q.seconds == SEC_W'(SEC_MAX);
   assign min_end = time_q.minutes == MIN_W'(MIN_MAX);
   assign hour_end = time_q.hours == HOURS_W'(HOURS_MAX);
   // one-second increment with cascaded rollover; an accepted load overrides the tick
   always_comb begin
      inc.seconds = sec_end ? '0 : time_q.seconds + 1'b1;
      inc.minutes = !sec_end ? time_q.minutes : min_end ? '0 : time_q.minutes + 1'b1;
      inc.hours = !(sec_end && min_end) ? time_q.hours : hour_end ? '0 : time_q.hours + 1'b1;
      time_d = ok ? sel : count ? inc : time_q;
   end
   // time registers and status pulses, all coincident with the updated fields
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         time_q <= '0;
         sec_pulse_q <= 1'b0;
         min_pulse_q <= 1'b0;
         day_wrap_q <= 1'b0;
         load_ack_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         time_q <= time_d;
         sec_pulse_q <= count;
         min_pulse_q <= count && sec_end;
         day_wrap_q <= count && sec_end && min_end && hour_end;
         load_ack_q <= ok;
         load_err_q <= hit && !ok;
      end
   assign bus.hours = time_q.hours;
   assign bus.minutes = time_q.minutes;
   assign bus.seconds = time_q.seconds;
   assign bus.sec_pulse = sec_pulse_q;
   assign bus.min_pulse = min_pulse_q;
   assign bus.day_wrap = day_wrap_q;
   assign bus.load_ack = load_ack_q;
   assign bus.load_err = load_err_q;
`ifdef TOD_ALARM_EN
   tod_time_t alarm_time_q;
   logic armed_q, alarm_q, alarm_d, alarm_ok;
   assign alarm_ok = bus.alarm_set && tod_valid(bus.alarm_time);
   // arming clears the flag; only a counted match sets it, and a match beats a same-cycle ack
   always_comb alarm_d = alarm_ok ? 1'b0 : (count && armed_q && inc == alarm_time_q) ? 1'b1 : bus.alarm_ack ? 1'b0 : alarm_q;
   // alarm compare value, arm state and sticky flag
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         alarm_time_q <= '0;
         armed_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         if (alarm_ok) begin
            alarm_time_q <= bus.alarm_time;
            armed_q <= 1'b1;
         end
         alarm_q <= alarm_d;
      end
   assign bus.alarm = alarm_q;
`endif
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed and random checks against a seconds-of-day reference model
module tb_time_of_day_counter;
   import tod_pkg::*;
   localparam int TPS = 4;
   localparam int NL = 2;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   int sod = 0;
   int pre = 0;
   logic e_sp = 0, e_mp = 0, e_dw = 0, e_ack = 0, e_err = 0;
`ifdef TOD_ALARM_EN
   int al_sod = 0;
   bit armed = 0;
   logic e_al = 0;
`endif
   always #5 clock = ~clock;
   time_of_day_counter_if #(.NUM_LOAD(NL)) bus ();
   time_of_day_counter #(.TICKS_PER_SEC(TPS), .NUM_LOAD(NL)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   function automatic logic [16:0] pk(input int h, input int m, input int s);
      return {h[4:0], m[5:0], s[5:0]};
   endfunction

   function automatic int to_sod(input logic [16:0] v, output bit valid);
      int h, m, s;
      h = int'(v[16:12]);
      m = int'(v[11:6]);
      s = int'(v[5:0]);
      valid = h < 24 && m < 60 && s < 60;
      return h * 3600 + m * 60 + s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      sod = 0;
      pre = 0;
      {e_sp, e_mp, e_dw, e_ack, e_err} = '0;
`ifdef TOD_ALARM_EN
      armed = 0;
      al_sod = 0;
      e_al = 0;
`endif
   endtask

   task automatic model_edge();
      int w, v;
      bit acc, tk, valid;
      w = -1;
      acc = 0;
      tk = bus.run && pre == TPS - 1;
      {e_sp, e_mp, e_dw, e_ack, e_err} = '0;
      for (int i = 0; i < NL; i++) if (bus.load[i] && w < 0) w = i;
      if (w >= 0) begin
         v = to_sod(bus.load_time[17*w +: 17], valid);
         if (valid) begin
            sod = v;
            pre = 0;
            e_ack = 1;
            acc = 1;
         end else e_err = 1;
      end
      if (!acc) begin
         if (tk) begin
            e_sp = 1;
            e_mp = (sod % 60 == 59);
            e_dw = (sod == 86399);
            sod = (sod + 1) % 86400;
            pre = 0;
         end else if (bus.run) pre++;
      end
`ifdef TOD_ALARM_EN
      v = to_sod(bus.alarm_time, valid);
      if (bus.alarm_set && valid) begin
         armed = 1;
         al_sod = v;
         e_al = 0;
      end else if (tk && !acc && armed && sod == al_sod) e_al = 1;
      else if (bus.alarm_ack) e_al = 0;
`endif
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".hours"}, 32'(bus.hours), sod / 3600);
      chk({tag, ".minutes"}, 32'(bus.minutes), (sod / 60) % 60);
      chk({tag, ".seconds"}, 32'(bus.seconds), sod % 60);
      chk({tag, ".sec_pulse"}, 32'(bus.sec_pulse), 32'(e_sp));
      chk({tag, ".min_pulse"}, 32'(bus.min_pulse), 32'(e_mp));
      chk({tag, ".day_wrap"}, 32'(bus.day_wrap), 32'(e_dw));
      chk({tag, ".load_ack"}, 32'(bus.load_ack), 32'(e_ack));
      chk({tag, ".load_err"}, 32'(bus.load_err), 32'(e_err));
`ifdef TOD_ALARM_EN
      chk({tag, ".alarm"}, 32'(bus.alarm), 32'(e_al));
`endif
   endtask

   task automatic cyc(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
      bus.load = '0;
`ifdef TOD_ALARM_EN
      bus.alarm_set = 1'b0;
      bus.alarm_ack = 1'b0;
`endif
   endtask

   initial begin
      bus.run = 1'b0;
      bus.load = '0;
      bus.load_time = '0;
`ifdef TOD_ALARM_EN
      bus.alarm_set = 1'b0;
      bus.alarm_time = '0;
      bus.alarm_ack = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      check_all("reset");
      reset = 1'b1;
      bus.run = 1'b1;
      repeat (12) cyc("count");
      chk("count12.seconds", 32'(bus.seconds), 3);
      bus.load = 2'b10;
      bus.load_time = {pk(23, 59, 58), 17'd0};
      cyc("wrap_load");
      chk("wrap_load.ack", 32'(bus.load_ack), 1);
      repeat (4) cyc("wrap_a");
      chk("wrap_a.time", {15'd0, bus.hours, bus.minutes, bus.seconds}, 32'(pk(23, 59, 59)));
      repeat (4) cyc("wrap_b");
      chk("wrap_b.time", {15'd0, bus.hours, bus.minutes, bus.seconds}, 0);
      chk("wrap_b.pulses", {29'd0, bus.sec_pulse, bus.min_pulse, bus.day_wrap}, 7);
      bus.load = 2'b11;
      bus.load_time = {pk(11, 0, 0), pk(10, 0, 0)};
      cyc("prio");
      chk("prio.hours", 32'(bus.hours), 10);
      chk("prio.ack", 32'(bus.load_ack), 1);
      cyc("prio_after");
      chk("prio_after.ack", 32'(bus.load_ack), 0);
      bus.load = 2'b01;
      bus.load_time = {17'd0, pk(24, 0, 0)};
      cyc("bad_load");
      chk("bad_load.err", 32'(bus.load_err), 1);
      chk("bad_load.hours", 32'(bus.hours), 10);
      repeat (6) cyc("after_bad");
      for (int k = 0; k < 8 && pre != TPS - 1; k++) cyc("align");
      bus.load = 2'b01;
      bus.load_time = {17'd0, pk(5, 6, 7)};
      cyc("tc_load");
      chk("tc_load.sec_pulse", 32'(bus.sec_pulse), 0);
      chk("tc_load.seconds", 32'(bus.seconds), 7);
      repeat (3) cyc("tc_hold");
      chk("tc_hold.seconds", 32'(bus.seconds), 7);
      cyc("tc_next");
      chk("tc_next.seconds", 32'(bus.seconds), 8);
      chk("tc_next.sec_pulse", 32'(bus.sec_pulse), 1);
      bus.run = 1'b0;
      repeat (7) cyc("hold");
      bus.load = 2'b10;
      bus.load_time = {pk(1, 2, 3), 17'd0};
      cyc("hold_load");
      chk("hold_load.minutes", 32'(bus.minutes), 2);
      bus.run = 1'b1;
      for (int n = 0; n < 600; n++) begin
         bus.run = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 5) == 0) begin
            bus.load = NL'($urandom_range(1, 3));
            for (int c = 0; c < NL; c++)
               bus.load_time[17*c +: 17] = ($urandom_range(0, 2) == 0) ? pk(23, 59, $urandom_range(54, 59))
                  : pk($urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61));
         end
`ifdef TOD_ALARM_EN
         bus.alarm_ack = $urandom_range(0, 15) == 0;
         if ($urandom_range(0, 30) == 0) begin
            bus.alarm_set = 1'b1;
            bus.alarm_time = pk(bus.hours, bus.minutes, $urandom_range(0, 61));
         end
`endif
         cyc("rand");
      end
`ifdef TOD_ALARM_EN
      bus.run = 1'b1;
      bus.alarm_set = 1'b1;
      bus.alarm_time = pk(0, 0, 2);
      bus.load = 2'b01;
      bus.load_time = {17'd0, pk(0, 0, 0)};
      cyc("al_set");
      repeat (7) cyc("al_wait");
      chk("al_wait.alarm", 32'(bus.alarm), 0);
      cyc("al_hit");
      chk("al_hit.alarm", 32'(bus.alarm), 1);
      chk("al_hit.seconds", 32'(bus.seconds), 2);
      repeat (6) cyc("al_sticky");
      chk("al_sticky.alarm", 32'(bus.alarm), 1);
      bus.alarm_ack = 1'b1;
      cyc("al_ack");
      chk("al_ack.alarm", 32'(bus.alarm), 0);
      bus.load = 2'b01;
      bus.load_time = {17'd0, pk(0, 0, 1)};
      cyc("al_reload");
      repeat (4) cyc("al_rehit");
      chk("al_rehit.alarm", 32'(bus.alarm), 1);
      repeat (2) cyc("al_pre_rst");
`endif
      bus.run = 1'b1;
      cyc("pre_rst");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("mid_rst");
      chk("mid_rst.seconds", 32'(bus.seconds), 0);
      @(posedge clock);
      #1;
      check_all("rst_held");
      reset = 1'b1;
      repeat (5) cyc("post_rst");
      chk("post_rst.seconds", 32'(bus.seconds), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Parametrised hours:minutes:seconds time-of-day counter driven from the system clock through an internal tick prescaler. It is the next generation of the team's clock-time counter: it adds a seconds field, a configurable prescale ratio, N prioritised load channels with range checking, a run/hold control and registered rollover pulses. It feeds the display multiplexer and the UART time-report path, and is loaded from the manual-set keypad logic and the UART command decoder.

## Interface
- `TICKS_PER_SEC`, default 50000000: clock cycles per second; legal range 2 to 2^27.
- `NUM_LOAD`, default 2: number of load channels; legal range 1 to 8.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state is cleared while low.
- `run` in 1: 1 = time advances; 0 = prescaler and time hold.
- `load` in NUM_LOAD: per-channel load strobe, one-cycle pulse expected; index 0 has highest priority.
- `load_time` in NUM_LOAD*17: per-channel value, channel i at bits [17*i+16 : 17*i], packed {hours[4:0], minutes[5:0], seconds[5:0]}.
- `hours` out 5: current hours, 0..23.
- `minutes` out 6: current minutes, 0..59.
- `seconds` out 6: current seconds, 0..59.
- `sec_pulse` out 1: one-cycle pulse; the seconds field changed on this edge due to counting.
- `min_pulse` out 1: one-cycle pulse; the minutes field incremented or wrapped due to counting.
- `day_wrap` out 1: one-cycle pulse; 23:59:59 rolled over to 00:00:00.
- `load_ack` out 1: one-cycle pulse; a load was accepted.
- `load_err` out 1: one-cycle pulse; a load was rejected as out of range.

## Operation
- Prescaler `pre` counts 0..TICKS_PER_SEC-1 while `run`=1. At terminal count with `run`=1 it returns to 0 and a second tick occurs.
- On a second tick:
  - seconds increments.
  - At 59, seconds goes to 0 and minutes increments.
  - At minutes 59, minutes goes to 0 and hours increments.
  - 23:59:59 goes to 00:00:00.
- Load arbitration: the lowest-index channel with `load`=1 wins. Other simultaneous strobes are ignored and produce no ack or error.
- The winning value is range-checked: hours ≤ 23, minutes ≤ 59, seconds ≤ 59.
  - In range: time takes the value, `pre` goes to 0, `load_ack`=1.
  - Out of range: time and `pre` are unchanged, `load_err`=1.
- A load has priority over a same-cycle second tick. On an accepted load, no increment occurs and no rollover pulses fire.
- On a rejected load, a same-cycle second tick proceeds normally.
- Loads are accepted while `run`=0.

## Timing
- Reset values: all time fields 0, `pre`=0, all pulse outputs 0.
- All outputs are registered. A pulse is high in the cycle after the edge that updated time, coincident with the new field values.
- The first `sec_pulse` after reset release with `run`=1 follows TICKS_PER_SEC rising edges.
- Time-field update period is TICKS_PER_SEC cycles with no jitter.
- Load latency is 1 cycle: strobe sampled at edge k, new value and `load_ack` visible after edge k.
- The next second tick occurs TICKS_PER_SEC edges after an accepted load.
- `run` deasserted at terminal count suppresses that tick. `pre` holds its value while `run`=0.
- Rollover pulses are coincident:
  - `min_pulse` is implied by every minute rollover.
  - `day_wrap` occurs together with `sec_pulse` and `min_pulse`.
- Reset asserted mid-operation clears everything immediately, including pending pulses.

## Configuration
- `TOD_ALARM_EN` defined: adds the following ports.
  - `alarm_set` in 1 and `alarm_time` in 17, same packing as `load_time`, range-checked as a load.
  - `alarm_ack` in 1.
  - `alarm` out 1.
- `alarm` behaviour with the macro defined:
  - Sets on the edge where a second tick makes time equal to the alarm value, and the alarm is armed.
  - Is sticky until `alarm_ack`. If ack and a match occur in the same cycle, the match wins.
  - A load that lands exactly on the alarm time does not set it.
  - An accepted `alarm_set` arms the alarm and clears `alarm`. Reset disarms the alarm.
- `TOD_ALARM_EN` not defined: these ports and the alarm logic are absent.

## Structure
- Package `tod_pkg`:
  - Constants HOURS_MAX=23, MIN_MAX=59, SEC_MAX=59; field widths 5/6/6; TIME_W=17.
  - Packed struct typedef `tod_time_t` {hours, minutes, seconds}.
  - Range-check function `tod_valid`.
- One sub-module, `tod_prescaler`:
  - Parameter TICKS_PER_SEC.
  - Inputs `clock`, `reset`, `run`, `clear`; output `tick`.
  - Counter width is $clog2(TICKS_PER_SEC).

## Test plan
Benches use TICKS_PER_SEC=4 and NUM_LOAD=2 unless stated otherwise.
- Reset release, `run`=1 → `sec_pulse` at cycles 4, 8, 12; seconds reads 1, 2, 3.
- Load channel 1 with 23:59:58 → `load_ack`. After 4 cycles: 23:59:59. After 4 more: 00:00:00 with `sec_pulse`, `min_pulse` and `day_wrap` all high.
- Channels 0 and 1 loaded in the same cycle with 10:00:00 and 11:00:00 → time 10:00:00, exactly one `load_ack`.
- Load 24:00:00 → `load_err`, time unchanged, counting continues uninterrupted.
- Load coinciding with terminal count → loaded value held for a full 4 cycles, no `sec_pulse` that cycle.
- With `TOD_ALARM_EN`: alarm set to 00:00:02, time loaded to 00:00:00.
  - `alarm` rises with the second `sec_pulse`.
  - `alarm` stays high until `alarm_ack`.
  - Reset mid-count drops `alarm` and the time to 0.
